decode_stage_fwd: RTL and testbench
===================================

Name: decode_stage_fwd

Overview:
Parametrised RV32I/RV64I decode stage. Covers operand read from an external register file, full rs1/rs2 forwarding from EXE/MEM/WB, immediate generation for all base formats, load-use and not-ready hazard stalls, and the DE->EXE pipeline latch with bubble/flush/hold. A saturating counter records hazard stall cycles. Sits between fetch and execute.

Parameters:
XLEN, 64, datapath width; 32 or 64 only
CNT_W, 16, width of hazard stall counter

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
DE_V  in  1  DE instruction valid
DE_IR  in  32  DE instruction
DE_PC  in  XLEN  DE instruction address
DE_NPC  in  XLEN  DE next PC
RF_RS1_DATA  in  XLEN  regfile port 1 data (combinational, for DE_RS1_ID)
RF_RS2_DATA  in  XLEN  regfile port 2 data
EXE_FWD_DATA  in  XLEN  EXE result of the instruction in the EXE latch (non-load)
MEM_V, MEM_LD_REG  in  1 each  MEM valid / writes rd
MEM_DRID  in  5  MEM rd
MEM_FWD_DATA  in  XLEN  MEM result (load data or ALU)
MEM_FWD_RDY  in  1  MEM_FWD_DATA valid this cycle
WB_V, WB_LD_REG  in  1 each  WB valid / writes rd
WB_DRID  in  5  WB rd
WB_DATA  in  XLEN  WB data
EXE_STALL  in  1  downstream hold
FLUSH  in  1  squash DE->EXE transfer
DE_RS1_ID, DE_RS2_ID  out  5 each  DE_IR[19:15], DE_IR[24:20] (combinational)
DE_STALL  out  1  hold fetch/DE latch
EXE_V, EXE_ECALL, EXE_ILLEGAL  out  1 each  registered
EXE_IR  out  32  registered
EXE_PC, EXE_NPC, EXE_ALU_ONE, EXE_ALU_TWO, EXE_RS2  out  XLEN each  registered
EXE_DRID  out  5  registered DE_IR[11:7]
EXE_LD_REG  out  1  registered: rd written and rd!=0
STALL_CNT  out  CNT_W  hazard stall cycles

Behaviour:
- Reset (RST_N=0 at edge): every registered output is 0, including STALL_CNT. Reset overrides FLUSH and stall.
- rs1 is used by opcodes 0110011, 0111011, 0010011, 0011011, 0000011, 0100011, 1100011, 1100111, and by 1110011 with funct3[2]=0. rs2 is used by 0110011, 0111011, 0100011, 1100011.
- Forward value per source, first match wins:
  1. EXE_V & EXE_LD_REG & EXE_DRID==id -> EXE_FWD_DATA.
  2. MEM_V & MEM_LD_REG & MEM_DRID==id -> MEM_FWD_DATA.
  3. WB_V & WB_LD_REG & WB_DRID==id -> WB_DATA.
  4. Otherwise RF data.
  - id==0 always yields 0.
- Load-use: stall_lu = DE_V & EXE_V & EXE_LD_REG & EXE_IR[6:0]==0000011 & EXE_DRID matches a used source.
- Not-ready: stall_nr = DE_V & (MEM selected for a used source) & !MEM_FWD_RDY.
- DE_STALL = stall_lu | stall_nr | EXE_STALL.
- Latch update priority: reset > FLUSH > EXE_STALL > (stall_lu|stall_nr) > load.
  - FLUSH: EXE_V<=0, other fields hold.
  - EXE_STALL: all hold.
  - Hazard: EXE_V<=0 (bubble), other fields hold.
  - Load: all fields take DE values; EXE_V<=DE_V.
- Immediates are sign-extended from IR[31] to XLEN:
  - I-type: loads, JALR, OP-IMM, OP-IMM-32.
  - S, B, U, J formats as standard.
  - Shift-imm (funct3[1:0]==01): shamt zero-extended from IR[25:20] for XLEN=64 OP-IMM, else IR[24:20].
- EXE_ALU_ONE: DE_PC for AUIPC/JAL; 0 for LUI; zero-extended IR[19:15] for CSR with funct3[2]=1; otherwise forwarded rs1.
- EXE_ALU_TWO: forwarded rs2 for 0110011/0111011; otherwise immediate.
- EXE_RS2: forwarded rs2, always.
- EXE_ECALL = (DE_IR==32'h00000073).
- EXE_ILLEGAL: opcode outside the listed set plus 0110111, 0010111, 1101111, 0001111; also set for 0011011/0111011 when XLEN=32.
- STALL_CNT: +1 on each cycle with (stall_lu|stall_nr) and !FLUSH & !EXE_STALL; saturates at all-ones.

Test Plan:
- XLEN=64. Reset mid-stream with EXE_V=1, STALL_CNT=5 -> all outputs 0 the cycle after the RST_N=0 edge.
- Back-to-back: addi x5,x0,-1 then add x6,x5,x5 with EXE_FWD_DATA=0xFFFF_FFFF_FFFF_FFFF -> no stall; EXE_ALU_ONE and EXE_ALU_TWO = all-ones.
- ld x7 in EXE, next add x8,x7,x1 -> DE_STALL=1 for one cycle, one bubble, STALL_CNT=1. Next cycle: MEM forward with MEM_FWD_RDY=1, data 0x1234 -> EXE_ALU_ONE=0x1234.
- MEM and WB both write x9 (0xAA, 0xBB) -> MEM value 0xAA wins. rd=x0 writes -> operand 0.
- Immediates: beq imm=-4 -> ALU_TWO=0xFFFF_FFFF_FFFF_FFFC; jal +2048 -> 0x800; slli shamt 63 -> 0x3F. With XLEN=32, addiw -> EXE_ILLEGAL=1.
- FLUSH together with stall_lu -> EXE_V=0 and STALL_CNT unchanged. EXE_STALL high 3 cycles -> EXE latch frozen. Force STALL_CNT to 0xFFFF -> holds at 0xFFFF.

Source files
------------

// File: rtl/decode_stage_fwd.sv
// rtl/decode_stage_fwd.sv - RV32I/RV64I decode stage with operand forwarding and DE->EXE latch
module decode_stage_fwd #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             DE_V,
  input  logic [31:0]      DE_IR,
  input  logic [XLEN-1:0]  DE_PC,
  input  logic [XLEN-1:0]  DE_NPC,
  input  logic [XLEN-1:0]  RF_RS1_DATA,
  input  logic [XLEN-1:0]  RF_RS2_DATA,
  input  logic [XLEN-1:0]  EXE_FWD_DATA,
  input  logic             MEM_V,
  input  logic             MEM_LD_REG,
  input  logic [4:0]       MEM_DRID,
  input  logic [XLEN-1:0]  MEM_FWD_DATA,
  input  logic             MEM_FWD_RDY,
  input  logic             WB_V,
  input  logic             WB_LD_REG,
  input  logic [4:0]       WB_DRID,
  input  logic [XLEN-1:0]  WB_DATA,
  input  logic             EXE_STALL,
  input  logic             FLUSH,
  output logic [4:0]       DE_RS1_ID,
  output logic [4:0]       DE_RS2_ID,
  output logic             DE_STALL,
  output logic             EXE_V,
  output logic             EXE_ECALL,
  output logic             EXE_ILLEGAL,
  output logic [31:0]      EXE_IR,
  output logic [XLEN-1:0]  EXE_PC,
  output logic [XLEN-1:0]  EXE_NPC,
  output logic [XLEN-1:0]  EXE_ALU_ONE,
  output logic [XLEN-1:0]  EXE_ALU_TWO,
  output logic [XLEN-1:0]  EXE_RS2,
  output logic [4:0]       EXE_DRID,
  output logic             EXE_LD_REG,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rs1_id, rs2_id, rd_id;

  assign opc    = DE_IR[6:0];
  assign f3     = DE_IR[14:12];
  assign rs1_id = DE_IR[19:15];
  assign rs2_id = DE_IR[24:20];
  assign rd_id  = DE_IR[11:7];

  assign DE_RS1_ID = rs1_id;
  assign DE_RS2_ID = rs2_id;

  logic             exe_v_q, exe_ecall_q, exe_illegal_q, exe_ld_reg_q;
  logic [31:0]      exe_ir_q;
  logic [XLEN-1:0]  exe_pc_q, exe_npc_q, exe_alu_one_q, exe_alu_two_q, exe_rs2_q;
  logic [4:0]       exe_drid_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic             exe_ecall_d, exe_illegal_d, exe_ld_reg_d;
  logic [XLEN-1:0]  exe_alu_one_d, exe_alu_two_d;

  logic rs1_used, rs2_used, legal, writes_rd;

  assign rs1_used = (opc inside {OPC_OP, OPC_OP32, OPC_OPIMM, OPC_OPIMM32, OPC_LOAD,
                                 OPC_STORE, OPC_BRANCH, OPC_JALR})
                  | ((opc == OPC_SYSTEM) & ~f3[2]);
  assign rs2_used = opc inside {OPC_OP, OPC_OP32, OPC_STORE, OPC_BRANCH};

  assign legal = (opc inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR,
                              OPC_SYSTEM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE})
               | ((XLEN == 64) & (opc inside {OPC_OP32, OPC_OPIMM32}));

  assign writes_rd = legal
                   & ((opc inside {OPC_OP, OPC_OP32, OPC_OPIMM, OPC_OPIMM32, OPC_LOAD,
                                   OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC})
                      | ((opc == OPC_SYSTEM) & (f3 != 3'b000)));

  // Forwarding: youngest producer first; x0 never forwards.
  logic exe_hit1, exe_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic mem_sel1, mem_sel2;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign exe_hit1 = exe_v_q & exe_ld_reg_q & (exe_drid_q == rs1_id);
  assign exe_hit2 = exe_v_q & exe_ld_reg_q & (exe_drid_q == rs2_id);
  assign mem_hit1 = MEM_V & MEM_LD_REG & (MEM_DRID == rs1_id);
  assign mem_hit2 = MEM_V & MEM_LD_REG & (MEM_DRID == rs2_id);
  assign wb_hit1  = WB_V & WB_LD_REG & (WB_DRID == rs1_id);
  assign wb_hit2  = WB_V & WB_LD_REG & (WB_DRID == rs2_id);

  assign mem_sel1 = (rs1_id != 5'd0) & ~exe_hit1 & mem_hit1;
  assign mem_sel2 = (rs2_id != 5'd0) & ~exe_hit2 & mem_hit2;

  assign rs1_val = (rs1_id == 5'd0) ? '0 :
                   exe_hit1 ? EXE_FWD_DATA :
                   mem_hit1 ? MEM_FWD_DATA :
                   wb_hit1  ? WB_DATA : RF_RS1_DATA;
  assign rs2_val = (rs2_id == 5'd0) ? '0 :
                   exe_hit2 ? EXE_FWD_DATA :
                   mem_hit2 ? MEM_FWD_DATA :
                   wb_hit2  ? WB_DATA : RF_RS2_DATA;

  logic stall_lu, stall_nr, hazard;

  assign stall_lu = DE_V & exe_v_q & exe_ld_reg_q & (exe_ir_q[6:0] == OPC_LOAD)
                  & ((rs1_used & (exe_drid_q == rs1_id)) | (rs2_used & (exe_drid_q == rs2_id)));
  assign stall_nr = DE_V & ~MEM_FWD_RDY & ((rs1_used & mem_sel1) | (rs2_used & mem_sel2));
  assign hazard   = stall_lu | stall_nr;
  assign DE_STALL = hazard | EXE_STALL;

  logic [XLEN-1:0] imm;
  logic            is_shift_imm;

  assign is_shift_imm = (opc inside {OPC_OPIMM, OPC_OPIMM32}) & (f3[1:0] == 2'b01);

  always_comb begin
    imm = XLEN'($signed(DE_IR[31:20]));
    if (is_shift_imm) begin
      if ((XLEN == 64) && (opc == OPC_OPIMM)) imm = XLEN'(DE_IR[25:20]);
      else                                    imm = XLEN'(DE_IR[24:20]);
    end else begin
      case (opc)
        OPC_STORE:          imm = XLEN'($signed({DE_IR[31:25], DE_IR[11:7]}));
        OPC_BRANCH:         imm = XLEN'($signed({DE_IR[31], DE_IR[7], DE_IR[30:25],
                                                 DE_IR[11:8], 1'b0}));
        OPC_LUI, OPC_AUIPC: imm = XLEN'($signed({DE_IR[31:12], 12'b0}));
        OPC_JAL:            imm = XLEN'($signed({DE_IR[31], DE_IR[19:12], DE_IR[20],
                                                 DE_IR[30:21], 1'b0}));
        default:            imm = XLEN'($signed(DE_IR[31:20]));
      endcase
    end
  end

  always_comb begin
    exe_alu_one_d = rs1_val;
    if ((opc == OPC_AUIPC) || (opc == OPC_JAL))    exe_alu_one_d = DE_PC;
    else if (opc == OPC_LUI)                       exe_alu_one_d = '0;
    else if ((opc == OPC_SYSTEM) && f3[2])         exe_alu_one_d = XLEN'(rs1_id);
    exe_alu_two_d = ((opc == OPC_OP) || (opc == OPC_OP32)) ? rs2_val : imm;
    exe_ecall_d   = (DE_IR == 32'h0000_0073);
    exe_illegal_d = ~legal;
    exe_ld_reg_d  = writes_rd & (rd_id != 5'd0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      exe_v_q       <= 1'b0;
      exe_ecall_q   <= 1'b0;
      exe_illegal_q <= 1'b0;
      exe_ld_reg_q  <= 1'b0;
      exe_ir_q      <= '0;
      exe_pc_q      <= '0;
      exe_npc_q     <= '0;
      exe_alu_one_q <= '0;
      exe_alu_two_q <= '0;
      exe_rs2_q     <= '0;
      exe_drid_q    <= '0;
    end else if (FLUSH || (!EXE_STALL && hazard)) begin
      exe_v_q <= 1'b0;
    end else if (!EXE_STALL) begin
      exe_v_q       <= DE_V;
      exe_ecall_q   <= exe_ecall_d;
      exe_illegal_q <= exe_illegal_d;
      exe_ld_reg_q  <= exe_ld_reg_d;
      exe_ir_q      <= DE_IR;
      exe_pc_q      <= DE_PC;
      exe_npc_q     <= DE_NPC;
      exe_alu_one_q <= exe_alu_one_d;
      exe_alu_two_q <= exe_alu_two_d;
      exe_rs2_q     <= rs2_val;
      exe_drid_q    <= rd_id;
    end
  end

  // Only cycles that actually produce a hazard bubble are counted.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
    end else if (hazard && !FLUSH && !EXE_STALL && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign EXE_V       = exe_v_q;
  assign EXE_ECALL   = exe_ecall_q;
  assign EXE_ILLEGAL = exe_illegal_q;
  assign EXE_IR      = exe_ir_q;
  assign EXE_PC      = exe_pc_q;
  assign EXE_NPC     = exe_npc_q;
  assign EXE_ALU_ONE = exe_alu_one_q;
  assign EXE_ALU_TWO = exe_alu_two_q;
  assign EXE_RS2     = exe_rs2_q;
  assign EXE_DRID    = exe_drid_q;
  assign EXE_LD_REG  = exe_ld_reg_q;
  assign STALL_CNT   = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_fwd.sv
// tb/tb_decode_stage_fwd.sv - directed bench for decode_stage_fwd (XLEN=64 and XLEN=32 instances)
module tb_decode_stage_fwd;

  localparam logic [31:0] I_ADDI  = 32'hFFF0_0293; // addi x5,x0,-1
  localparam logic [31:0] I_ADD6  = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] I_LD7   = 32'h0001_3383; // ld   x7,0(x2)
  localparam logic [31:0] I_ADD8  = 32'h0013_8433; // add  x8,x7,x1
  localparam logic [31:0] I_ADD10 = 32'h0004_8533; // add  x10,x9,x0
  localparam logic [31:0] I_BEQ   = 32'hFE00_0EE3; // beq  x0,x0,-4
  localparam logic [31:0] I_JAL   = 32'h0010_00EF; // jal  x1,+2048
  localparam logic [31:0] I_SLLI  = 32'h03F0_9093; // slli x1,x1,63
  localparam logic [31:0] I_LUI   = 32'h8000_01B7; // lui  x3,0x80000
  localparam logic [31:0] I_ECALL = 32'h0000_0073;
  localparam logic [31:0] I_BAD   = 32'h0000_007F;
  localparam logic [31:0] I_ADDIW = 32'h0010_809B; // addiw x1,x1,1

  logic        clk = 1'b0;
  logic        rst_n, de_v, mem_v, mem_ld, mem_rdy, wb_v, wb_ld, exe_stall, flush;
  logic [31:0] de_ir;
  logic [63:0] de_pc, de_npc, rf1, rf2, exe_fwd, mem_fwd, wb_data;
  logic [4:0]  mem_drid, wb_drid;

  logic [4:0]  rs1_id, rs2_id, exe_drid;
  logic        de_stall, exe_v, exe_ecall, exe_ill, exe_ld;
  logic [31:0] exe_ir;
  logic [63:0] exe_pc, exe_npc, alu_one, alu_two, exe_rs2;
  logic [15:0] cnt;

  logic [4:0]  n_rs1_id, n_rs2_id, n_drid;
  logic        n_de_stall, n_v, n_ecall, n_ill, n_ld;
  logic [31:0] n_ir, n_pc, n_npc, n_one, n_two, n_rs2;
  logic [1:0]  n_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_fwd #(.XLEN(64), .CNT_W(16)) u64 (
    .CLK(clk), .RST_N(rst_n), .DE_V(de_v), .DE_IR(de_ir), .DE_PC(de_pc), .DE_NPC(de_npc),
    .RF_RS1_DATA(rf1), .RF_RS2_DATA(rf2), .EXE_FWD_DATA(exe_fwd),
    .MEM_V(mem_v), .MEM_LD_REG(mem_ld), .MEM_DRID(mem_drid), .MEM_FWD_DATA(mem_fwd),
    .MEM_FWD_RDY(mem_rdy), .WB_V(wb_v), .WB_LD_REG(wb_ld), .WB_DRID(wb_drid), .WB_DATA(wb_data),
    .EXE_STALL(exe_stall), .FLUSH(flush), .DE_RS1_ID(rs1_id), .DE_RS2_ID(rs2_id),
    .DE_STALL(de_stall), .EXE_V(exe_v), .EXE_ECALL(exe_ecall), .EXE_ILLEGAL(exe_ill),
    .EXE_IR(exe_ir), .EXE_PC(exe_pc), .EXE_NPC(exe_npc), .EXE_ALU_ONE(alu_one),
    .EXE_ALU_TWO(alu_two), .EXE_RS2(exe_rs2), .EXE_DRID(exe_drid), .EXE_LD_REG(exe_ld),
    .STALL_CNT(cnt)
  );

  decode_stage_fwd #(.XLEN(32), .CNT_W(2)) u32 (
    .CLK(clk), .RST_N(rst_n), .DE_V(de_v), .DE_IR(de_ir), .DE_PC(de_pc[31:0]),
    .DE_NPC(de_npc[31:0]), .RF_RS1_DATA(rf1[31:0]), .RF_RS2_DATA(rf2[31:0]),
    .EXE_FWD_DATA(exe_fwd[31:0]), .MEM_V(mem_v), .MEM_LD_REG(mem_ld), .MEM_DRID(mem_drid),
    .MEM_FWD_DATA(mem_fwd[31:0]), .MEM_FWD_RDY(mem_rdy), .WB_V(wb_v), .WB_LD_REG(wb_ld),
    .WB_DRID(wb_drid), .WB_DATA(wb_data[31:0]), .EXE_STALL(exe_stall), .FLUSH(flush),
    .DE_RS1_ID(n_rs1_id), .DE_RS2_ID(n_rs2_id), .DE_STALL(n_de_stall), .EXE_V(n_v),
    .EXE_ECALL(n_ecall), .EXE_ILLEGAL(n_ill), .EXE_IR(n_ir), .EXE_PC(n_pc), .EXE_NPC(n_npc),
    .EXE_ALU_ONE(n_one), .EXE_ALU_TWO(n_two), .EXE_RS2(n_rs2), .EXE_DRID(n_drid),
    .EXE_LD_REG(n_ld), .STALL_CNT(n_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    de_v = 1'b0; de_ir = 32'h0; de_pc = 64'h0; de_npc = 64'h0; rf1 = 64'h0; rf2 = 64'h0;
    exe_fwd = 64'h0; mem_v = 1'b0; mem_ld = 1'b0; mem_drid = 5'd0; mem_fwd = 64'h0;
    mem_rdy = 1'b1; wb_v = 1'b0; wb_ld = 1'b0; wb_drid = 5'd0; wb_data = 64'h0;
    exe_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic clear_exe();
    clear_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0; de_v = 1'b1; de_ir = I_ADD6; de_pc = 64'h40; flush = 1'b1;
    step(); step();
    checks++; if (exe_v !== 1'b0) begin errors++; $display("FAIL rst_exe_v got=%h exp=0", exe_v); end
    checks++; if (exe_ir !== 32'h0) begin errors++; $display("FAIL rst_exe_ir got=%h exp=0", exe_ir); end
    checks++; if (exe_pc !== 64'h0) begin errors++; $display("FAIL rst_exe_pc got=%h exp=0", exe_pc); end
    checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got=%h exp=0", cnt); end
    checks++; if (n_cnt !== 2'h0) begin errors++; $display("FAIL rst_cnt32 got=%h exp=0", n_cnt); end
    rst_n = 1'b1; flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_exe();
    de_v = 1'b1; de_ir = I_ADDI;
    step();
    checks++; if (alu_two !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b2b_addi_imm got=%h exp=ffffffffffffffff", alu_two); end
    checks++; if ({exe_v, exe_ld, exe_drid} !== {1'b1, 1'b1, 5'd5}) begin errors++; $display("FAIL b2b_addi_ctl got=%b exp=1100101", {exe_v, exe_ld, exe_drid}); end
    de_ir = I_ADD6; exe_fwd = 64'hFFFF_FFFF_FFFF_FFFF; rf1 = 64'h77; rf2 = 64'h77;
    #1;
    checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL b2b_no_stall got=%b exp=0", de_stall); end
    step();
    checks++; if (alu_one !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b2b_one got=%h exp=ffffffffffffffff", alu_one); end
    checks++; if (alu_two !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b2b_two got=%h exp=ffffffffffffffff", alu_two); end
    checks++; if (exe_rs2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL b2b_rs2 got=%h exp=ffffffffffffffff", exe_rs2); end
  endtask

  task automatic test_load_use();
    clear_exe();
    de_v = 1'b1; de_ir = I_LD7;
    step();
    de_ir = I_ADD8; rf2 = 64'h10;
    #1;
    checks++; if (de_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", de_stall); end
    step();
    checks++; if (exe_v !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b exp=0", exe_v); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", cnt); end
    checks++; if (exe_ir !== I_LD7) begin errors++; $display("FAIL lu_ir_hold got=%h exp=%h", exe_ir, I_LD7); end
    mem_v = 1'b1; mem_ld = 1'b1; mem_drid = 5'd7; mem_fwd = 64'h1234; mem_rdy = 1'b1;
    #1;
    checks++; if (de_stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", de_stall); end
    step();
    checks++; if (exe_v !== 1'b1) begin errors++; $display("FAIL lu_load_v got=%b exp=1", exe_v); end
    checks++; if (alu_one !== 64'h1234) begin errors++; $display("FAIL lu_mem_fwd got=%h exp=1234", alu_one); end
    checks++; if (alu_two !== 64'h10) begin errors++; $display("FAIL lu_rf_rs2 got=%h exp=10", alu_two); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_after got=%0d exp=1", cnt); end
  endtask

  task automatic test_mem_wb_priority();
    clear_exe();
    de_v = 1'b1; de_ir = I_ADD10; rf1 = 64'h11; rf2 = 64'h55;
    mem_v = 1'b1; mem_ld = 1'b1; mem_drid = 5'd9; mem_fwd = 64'hAA; mem_rdy = 1'b1;
    wb_v = 1'b1; wb_ld = 1'b1; wb_drid = 5'd9; wb_data = 64'hBB;
    step();
    checks++; if (alu_one !== 64'hAA) begin errors++; $display("FAIL mem_over_wb got=%h exp=aa", alu_one); end
    checks++; if (alu_two !== 64'h0) begin errors++; $display("FAIL x0_rs2 got=%h exp=0", alu_two); end
    mem_drid = 5'd0; mem_fwd = 64'hDD;
    step();
    checks++; if (alu_one !== 64'hBB) begin errors++; $display("FAIL wb_fwd got=%h exp=bb", alu_one); end
    checks++; if (alu_two !== 64'h0) begin errors++; $display("FAIL x0_mem_write got=%h exp=0", alu_two); end
    wb_v = 1'b0;
    step();
    checks++; if (alu_one !== 64'h11) begin errors++; $display("FAIL rf_path got=%h exp=11", alu_one); end
  endtask

  task automatic test_immediates();
    clear_exe();
    de_v = 1'b1; de_ir = I_BEQ;
    step();
    checks++; if (alu_two !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL imm_b got=%h exp=fffffffffffffffc", alu_two); end
    checks++; if (exe_ld !== 1'b0) begin errors++; $display("FAIL beq_ld_reg got=%b exp=0", exe_ld); end
    de_ir = I_JAL; de_pc = 64'h1000;
    step();
    checks++; if (alu_two !== 64'h800) begin errors++; $display("FAIL imm_j got=%h exp=800", alu_two); end
    checks++; if (alu_one !== 64'h1000) begin errors++; $display("FAIL jal_pc got=%h exp=1000", alu_one); end
    de_ir = I_SLLI;
    step();
    checks++; if (alu_two !== 64'h3F) begin errors++; $display("FAIL imm_shamt got=%h exp=3f", alu_two); end
    de_ir = I_LUI;
    step();
    checks++; if (alu_two !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL imm_u got=%h exp=ffffffff80000000", alu_two); end
    checks++; if (alu_one !== 64'h0) begin errors++; $display("FAIL lui_one got=%h exp=0", alu_one); end
    de_ir = I_ECALL;
    step();
    checks++; if ({exe_ecall, exe_ill} !== 2'b10) begin errors++; $display("FAIL ecall got=%b exp=10", {exe_ecall, exe_ill}); end
    de_ir = I_BAD;
    step();
    checks++; if ({exe_ecall, exe_ill} !== 2'b01) begin errors++; $display("FAIL bad_opc got=%b exp=01", {exe_ecall, exe_ill}); end
    de_ir = I_ADDIW;
    step();
    checks++; if (n_ill !== 1'b1) begin errors++; $display("FAIL addiw_rv32 got=%b exp=1", n_ill); end
    checks++; if (exe_ill !== 1'b0) begin errors++; $display("FAIL addiw_rv64 got=%b exp=0", exe_ill); end
  endtask

  task automatic test_flush();
    clear_exe();
    de_v = 1'b1; de_ir = I_LD7;
    step();
    de_ir = I_ADD8; flush = 1'b1;
    #1;
    checks++; if (de_stall !== 1'b1) begin errors++; $display("FAIL flush_de_stall got=%b exp=1", de_stall); end
    step();
    checks++; if (exe_v !== 1'b0) begin errors++; $display("FAIL flush_v got=%b exp=0", exe_v); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", cnt); end
    checks++; if (exe_ir !== I_LD7) begin errors++; $display("FAIL flush_ir_hold got=%h exp=%h", exe_ir, I_LD7); end
    flush = 1'b0;
  endtask

  task automatic test_exe_stall();
    clear_exe();
    de_v = 1'b1; de_ir = I_ADDI; de_pc = 64'h200;
    step();
    de_ir = I_JAL; de_pc = 64'h300; exe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (de_stall !== 1'b1) begin errors++; $display("FAIL hold_de_stall[%0d] got=%b exp=1", i, de_stall); end
      step();
      checks++; if ({exe_v, exe_ir} !== {1'b1, I_ADDI}) begin errors++; $display("FAIL hold_ir[%0d] got=%h exp=%h", i, {exe_v, exe_ir}, {1'b1, I_ADDI}); end
      checks++; if ({exe_pc, alu_two} !== {64'h200, 64'hFFFF_FFFF_FFFF_FFFF}) begin errors++; $display("FAIL hold_data[%0d] got=%h/%h exp=200/ffffffffffffffff", i, exe_pc, alu_two); end
    end
    exe_stall = 1'b0;
    step();
    checks++; if ({exe_ir, exe_pc} !== {I_JAL, 64'h300}) begin errors++; $display("FAIL hold_release got=%h/%h exp=%h/300", exe_ir, exe_pc, I_JAL); end
    checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL hold_cnt got=%0d exp=1", cnt); end
  endtask

  task automatic test_saturate_and_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    de_v = 1'b1; de_ir = I_ADD10; de_npc = 64'h44;
    mem_v = 1'b1; mem_ld = 1'b1; mem_drid = 5'd9; mem_fwd = 64'h42; mem_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (cnt !== 16'(i + 1)) begin errors++; $display("FAIL nr_cnt[%0d] got=%0d exp=%0d", i, cnt, i + 1); end
      checks++; if (n_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, n_cnt, (i < 3) ? i + 1 : 3); end
    end
    checks++; if (exe_v !== 1'b0) begin errors++; $display("FAIL nr_bubble got=%b exp=0", exe_v); end
    mem_rdy = 1'b1;
    step();
    checks++; if ({exe_v, alu_one} !== {1'b1, 64'h42}) begin errors++; $display("FAIL nr_release got=%h exp=10000000000000042", {exe_v, alu_one}); end
    checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL nr_cnt_final got=%0d exp=5", cnt); end
    rst_n = 1'b0; flush = 1'b1; exe_stall = 1'b1; mem_rdy = 1'b0;
    step();
    checks++; if ({exe_v, exe_ecall, exe_ill, exe_ld, exe_drid} !== 9'h0) begin errors++; $display("FAIL mrst_ctl got=%h exp=0", {exe_v, exe_ecall, exe_ill, exe_ld, exe_drid}); end
    checks++; if ({exe_ir, exe_pc, exe_npc} !== 160'h0) begin errors++; $display("FAIL mrst_pc got=%h exp=0", {exe_ir, exe_pc, exe_npc}); end
    checks++; if ({alu_one, alu_two, exe_rs2} !== 192'h0) begin errors++; $display("FAIL mrst_data got=%h exp=0", {alu_one, alu_two, exe_rs2}); end
    checks++; if ({cnt, n_cnt} !== 18'h0) begin errors++; $display("FAIL mrst_cnt got=%h exp=0", {cnt, n_cnt}); end
    rst_n = 1'b1; flush = 1'b0; exe_stall = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_mem_wb_priority();
    test_immediates();
    test_flush();
    test_exe_stall();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
